skid_buffer: RTL and testbench



---
 rtl/skid_pkg.sv | 21 ++
 rtl/data_reg.sv | 25 ++
 rtl/skid_buffer.sv | 103 ++++++++++
 tb/tb_skid_buffer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/skid_pkg.sv
// Shared types for the two-entry skid buffer.
package skid_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Occupancy encoding matches the state encoding, so count is the state itself.
  localparam logic [STATE_W-1:0] CNT_EMPTY = 2'd0;
  localparam logic [STATE_W-1:0] CNT_BUSY  = 2'd1;
  localparam logic [STATE_W-1:0] CNT_FULL  = 2'd2;

  function automatic logic [STATE_W-1:0] state_to_count(input state_t s);
    return STATE_W'(s);
  endfunction

endpackage

// File: rtl/data_reg.sv
// Parameterised enable register with synchronous active-high clear.
module data_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  // Load on enable, clear on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer; all handshake outputs come straight from flops.
module skid_buffer
  import skid_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             main_en, skid_en, main_from_skid;
  logic [WIDTH-1:0] main_d, main_q, skid_q;

  // Next state and register load strobes; flush overrides every handshake.
  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_valid) begin
            main_en = 1'b1;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (in_valid && out_ready) begin
            main_en = 1'b1;
          end else if (in_valid) begin
            skid_en = 1'b1;
            state_d = FULL;
          end else if (out_ready) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_ready) begin
            main_en        = 1'b1;
            main_from_skid = 1'b1;
            state_d        = BUSY;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  // State and handshake flops; reset wins over flush and handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  data_reg #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .reset (reset),
    .en_i  (main_en),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  data_reg #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .reset (reset),
    .en_i  (skid_en),
    .d_i   (in_data),
    .q_o   (skid_q)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign count     = state_to_count(state_q);

endmodule

// File: tb/tb_skid_buffer.sv
// Directed self-checking bench for skid_buffer.
module tb_skid_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] count;

  int checks   = 0;
  int failures = 0;

  skid_buffer #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ov, input logic ir,
                         input logic [1:0] cnt, input logic [7:0] dat);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(ir));
    chk({tag, ".count"},     32'(count),     32'(cnt));
    if (ov) chk({tag, ".out_data"}, 32'(out_data), 32'(dat));
  endtask

  initial begin
    int         idx;
    int         exp_word;
    int         rcv;
    int         cyc;
    logic       in_fire;
    logic       out_fire;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

    // Reset then idle
    tick(); tick();
    reset = 1'b0;
    chk_all("reset", 1'b0, 1'b1, 2'd0, 8'h00);
    chk("reset.out_data", 32'(out_data), 32'h00);
    tick();
    chk_all("idle", 1'b0, 1'b1, 2'd0, 8'h00);

    // Streaming pass-through, one beat per cycle
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      tick();
      chk_all($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, 8'(i));
    end
    in_valid = 1'b0;
    tick();
    chk_all("stream_drain", 1'b0, 1'b1, 2'd0, 8'h00);

    // Backpressure
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 8'hA1;
    tick();
    chk_all("bp_a1", 1'b1, 1'b1, 2'd1, 8'hA1);
    in_data = 8'hA2;
    tick();
    chk_all("bp_a2", 1'b1, 1'b0, 2'd2, 8'hA1);
    in_data = 8'hA3;
    tick();
    chk_all("bp_hold1", 1'b1, 1'b0, 2'd2, 8'hA1);
    tick();
    chk_all("bp_hold2", 1'b1, 1'b0, 2'd2, 8'hA1);
    out_ready = 1'b1;
    tick();
    chk_all("bp_out_a2", 1'b1, 1'b1, 2'd1, 8'hA2);
    tick();
    chk_all("bp_out_a3", 1'b1, 1'b1, 2'd1, 8'hA3);
    in_valid = 1'b0;
    tick();
    chk_all("bp_drain", 1'b0, 1'b1, 2'd0, 8'h00);

    // Alternating out_ready with continuous input
    idx = 32'h20; exp_word = 32'h20; rcv = 0; cyc = 0;
    while (rcv < 16 && cyc < 100) begin
      out_ready = cyc[0] ? 1'b0 : 1'b1;
      in_valid  = (idx <= 32'h2F);
      in_data   = 8'(idx);
      #1;
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        chk($sformatf("alt_word%0d", rcv), 32'(out_data), 32'(exp_word));
        exp_word++;
        rcv++;
      end
      chk("alt_count_le2", 32'(count <= 2'd2), 32'd1);
      tick();
      if (in_fire) idx++;
      cyc++;
    end
    chk("alt_received", 32'(rcv), 32'd16);
    chk("alt_consumed", 32'(idx), 32'h30);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk_all("alt_drain", 1'b0, 1'b1, 2'd0, 8'h00);

    // Flush while FULL with a word offered on the same edge
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hB1;
    tick();
    in_data = 8'hB2;
    tick();
    chk_all("fl_full", 1'b1, 1'b0, 2'd2, 8'hB1);
    flush = 1'b1; in_data = 8'hB3;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk_all("fl_after", 1'b0, 1'b1, 2'd0, 8'h00);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("fl_quiet%0d", i), 1'b0, 1'b1, 2'd0, 8'h00);
    end

    // Reset while BUSY with handshakes active on the reset edge
    in_valid = 1'b1; in_data = 8'hC1; out_ready = 1'b0;
    tick();
    chk_all("rst_busy", 1'b1, 1'b1, 2'd1, 8'hC1);
    reset = 1'b1; in_data = 8'hC2; out_ready = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    chk_all("rst_mid", 1'b0, 1'b1, 2'd0, 8'h00);
    chk("rst_mid.out_data", 32'(out_data), 32'h00);
    tick();
    chk_all("rst_quiet", 1'b0, 1'b1, 2'd0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
